frame_read_arbiter: RTL
=======================

FRAME_READ_ARBITER -- requirements
Module: frame_read_arbiter

Interface
REQ-001 Parameter AW, default 15: frame-buffer address width in bits.
REQ-002 Parameter DW, default 8: pixel data width in bits.
REQ-003 Parameter STARVE_MAX, default 16: consecutive denied CPU cycles before a forced CPU grant.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port list:
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous active-low reset.
- vid_req  in  1: display pixel fetch request, may be high every cycle.
- vid_addr  in  AW: display fetch address.
- vid_data  out  DW: display pixel data.
- vid_valid  out  1: vid_data valid pulse.
- vid_drop  out  1: pulse when a display fetch was discarded.
- cpu_req  in  1: processor read request, level, held until cpu_ack.
- cpu_addr  in  AW: processor read address, stable while cpu_req=1.
- cpu_data  out  DW: processor read data.
- cpu_ack  out  1: one-cycle completion pulse.
- cpu_busy  out  1: high while a CPU read is in flight.
- mem_addr  out  AW: registered read address to the buffer read port.
- mem_rdata  in  DW: buffer read data, valid one cycle after mem_addr is sampled.

Function
REQ-006 Grant is decided at each rising edge E; mem_addr SHALL load the granted address at E and hold its value when nothing is granted.
REQ-007 Display has fixed priority: vid_req=1 at E SHALL always be granted unless a forced CPU grant (REQ-012) applies.
REQ-008 A display grant at E SHALL produce vid_data=mem_rdata and vid_valid=1 registered at E+2 (latency 2 cycles), one pulse per grant, back-to-back with no bubbles.
REQ-009 The CPU FSM SHALL have four states: C_IDLE, C_RD, C_CAP and C_DONE.
- C_IDLE->C_RD at E when cpu_req=1 and vid_req=0 (or on a forced grant); mem_addr<=cpu_addr.
- C_RD->C_CAP at E+1 unconditionally.
- C_CAP->C_DONE at E+2; cpu_data<=mem_rdata, cpu_ack<=1.
- C_DONE->C_IDLE at E+3; cpu_ack<=0.
REQ-010 cpu_req SHALL be sampled only in C_IDLE; cpu_busy=1 in C_RD, C_CAP and C_DONE.
REQ-011 A display grant during C_RD, C_CAP or C_DONE SHALL proceed normally; the pipeline SHALL tag each slot with its owner so data never routes to the wrong requester.
REQ-012 (guarded) The starve counter SHALL increment on each edge with state=C_IDLE, cpu_req=1 and vid_req=1, clear otherwise, and saturate at STARVE_MAX; at STARVE_MAX the next CPU decision SHALL grant the CPU, clear the counter and, if vid_req=1 that edge, pulse vid_drop and produce no vid_valid for that fetch.
REQ-013 cpu_data SHALL hold its last value until the next capture; vid_data SHALL hold between pulses.
REQ-014 The counter SHALL be wide enough for STARVE_MAX and never wrap.

Reset
REQ-015 While rst_n=0 the block SHALL hold mem_addr=0, vid_data=0, vid_valid=0, vid_drop=0, cpu_data=0, cpu_ack=0, cpu_busy=0, CPU FSM=C_IDLE, owner tags cleared and counter=0.
REQ-016 A reset asserted mid-read SHALL abandon all in-flight reads and issue no cpu_ack or vid_valid for them after release.
REQ-017 The first grant SHALL occur at the first rising edge after rst_n deasserts.

Configuration
REQ-018 With macro FRAME_ARB_STARVE_GUARD_EN defined, REQ-012 SHALL apply.
REQ-019 Without FRAME_ARB_STARVE_GUARD_EN, the block SHALL omit the counter, tie vid_drop to 0 and grant the CPU only on edges with vid_req=0.

Verification
REQ-020 Reset check: rst_n low, then vid_req=1 and vid_addr=0x0005 at edge 1 with the RAM holding 0x25 -> mem_addr=0x0005 after edge 1, vid_valid=1 and vid_data=0x25 after edge 3.
REQ-021 CPU-only read: cpu_req=1, cpu_addr=0x7FFF, vid_req=0 -> cpu_busy=1 for 3 cycles, cpu_ack high for one cycle with cpu_data=mem[0x7FFF], and no vid_valid.
REQ-022 Back-to-back video: vid_req=1 for 8 cycles at addresses 0..7 -> 8 consecutive vid_valid pulses, in order, each with latency 2.
REQ-023 Guard enabled: vid_req=1 continuously and cpu_req=1 -> forced CPU grant after 16 denied edges, exactly one vid_drop pulse, then cpu_ack 2 cycles later.
REQ-024 Guard disabled: same stimulus as REQ-023 -> no cpu_ack while vid_req=1 and vid_drop never asserts; cpu_ack follows 3 cycles after vid_req falls.
REQ-025 Mid-read reset: rst_n pulsed low in C_CAP -> no cpu_ack; cpu_busy=0 and FSM in C_IDLE after release.

Source files
------------

// File: rtl/frame_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_read_arbiter
// Desc     : Shares one registered frame-buffer read port between a fixed-
//            priority display fetch stream and a CPU read FSM. Define
//            FRAME_ARB_STARVE_GUARD_EN to enable the CPU starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module frame_read_arbiter #(
    parameter int AW         = 15,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    output logic          vid_drop,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_data,
    output logic          cpu_ack,
    output logic          cpu_busy,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_RD   = 2'd1,
        C_CAP  = 2'd2,
        C_DONE = 2'd3
    } cpu_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    cpu_state_t r_state;
    cpu_state_t w_state_next;
    owner_t     r_own_s1;
    owner_t     r_own_s2;
    owner_t     w_own_new;
    logic       w_cpu_grant;
    logic       w_vid_grant;
    logic       w_force;

    if (STARVE_MAX < 1) begin : g_param_check
        $error("frame_read_arbiter: STARVE_MAX must be at least 1");
    end

`ifdef FRAME_ARB_STARVE_GUARD_EN
    localparam int            CW           = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_STARVE_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] r_starve;
    logic          r_vid_drop;

    assign w_force = (r_state == C_IDLE) && cpu_req && (r_starve == C_STARVE_MAX);

    // Counts only edges where the CPU is waiting on a display win; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve   <= '0;
            r_vid_drop <= 1'b0;
        end else begin
            r_vid_drop <= w_force && vid_req;
            if (w_force || !((r_state == C_IDLE) && cpu_req && vid_req)) begin
                r_starve <= '0;
            end else if (r_starve != C_STARVE_MAX) begin
                r_starve <= r_starve + CW'(1);
            end
        end
    end

    assign vid_drop = r_vid_drop;
`else
    assign w_force  = 1'b0;
    assign vid_drop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cpu_grant  = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (cpu_req && (!vid_req || w_force)) begin
                    w_cpu_grant  = 1'b1;
                    w_state_next = C_RD;
                end
            end
            C_RD:    w_state_next = C_CAP;
            C_CAP:   w_state_next = C_DONE;
            C_DONE:  w_state_next = C_IDLE;
            default: w_state_next = C_IDLE;
        endcase
    end

    assign w_vid_grant = vid_req && !w_force;

    always_comb begin
        w_own_new = OWN_NONE;
        if (w_vid_grant) begin
            w_own_new = OWN_VID;
        end else if (w_cpu_grant) begin
            w_own_new = OWN_CPU;
        end
    end

    // Two-deep owner pipeline matches the read port latency, so returning
    // data is steered by who issued the address, not by current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            r_own_s1  <= OWN_NONE;
            r_own_s2  <= OWN_NONE;
            vid_data  <= '0;
            vid_valid <= 1'b0;
            cpu_data  <= '0;
        end else begin
            if (w_vid_grant) begin
                mem_addr <= vid_addr;
            end else if (w_cpu_grant) begin
                mem_addr <= cpu_addr;
            end
            r_own_s1  <= w_own_new;
            r_own_s2  <= r_own_s1;
            vid_valid <= (r_own_s2 == OWN_VID);
            if (r_own_s2 == OWN_VID) begin
                vid_data <= mem_rdata;
            end
            if ((r_own_s2 == OWN_CPU) && (r_state == C_CAP)) begin
                cpu_data <= mem_rdata;
            end
        end
    end

    assign cpu_ack  = (r_state == C_DONE);
    assign cpu_busy = (r_state != C_IDLE);

endmodule
`default_nettype wire
